l2k_exec_stage: RTL and testbench
=================================

// Module: l2k_exec_stage
// PURPOSE
//  Execute stage of the Limn2600 pipeline. Accepts decoded ALU ops from decode
//  via valid/ready, selects and forwards operands, and drives the combinational
//  l2k_alu through alu_op/alu_a/alu_b. Captures alu_c into a 2-entry result
//  buffer that feeds writeback through a second valid/ready handshake.
// PARAMETERS
//  XLEN   32  datapath width
//  RIDXW  5   register index width (32 GPRs; r0 reads as zero)
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      asynchronous active-low reset
//  flush       in   1      sync: discard all buffered results and the current input
//  in_valid    in   1      decode offers an op
//  in_ready    out  1      stage accepts the op this cycle
//  in_op       in   3      ALU opcode (111 add, 110 sub, 011 and, 010 xor, 001 or, 101 slt, 100 slts, 000 nop)
//  in_rs1      in   RIDXW  source index for operand A (used for forwarding)
//  in_rs2      in   RIDXW  source index for operand B (used for forwarding)
//  in_a        in   XLEN   register-file value of rs1
//  in_b        in   XLEN   register-file value of rs2
//  in_use_imm  in   1      1: operand B = in_imm, no forwarding on B
//  in_imm      in   XLEN   immediate, already extended by decode
//  in_rd       in   RIDXW  destination index
//  alu_op      out  3      to l2k_alu.op
//  alu_a       out  XLEN   to l2k_alu.a
//  alu_b       out  XLEN   to l2k_alu.b
//  alu_c       in   XLEN   from l2k_alu.c; combinational in the same cycle
//  out_valid   out  1      head result valid
//  out_ready   in   1      writeback consumes the head; commit on this edge
//  out_rd      out  RIDXW  head destination
//  out_result  out  XLEN   head result
// BEHAVIOUR
//  Reset: buffer empty; out_valid=0, out_rd=0, out_result=0; in_ready=1 once released.
//  Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  in_ready = !flush & (count<2 | out_ready). A push and a pop in the same cycle when
//   full are legal; count is unchanged.
//  Latency: an op accepted at edge N with the buffer empty shows out_valid=1 after edge N.
//  Order: strict FIFO; out_rd/out_result stay stable while out_valid & !out_ready.
//  Operands, evaluated combinationally in the accept cycle:
//   - A = in_a, unless in_rs1!=0 and matches the rd of a buffered entry: take the
//     youngest matching entry's result.
//   - B = in_imm if in_use_imm. Otherwise apply the same forwarding rule to in_rs2/in_b.
//   - An entry popping in the same cycle is still a forwarding source (regfile
//     write lands at that edge).
//   - Index 0 never forwards; rs=0 yields in_a/in_b unchanged (decode supplies 0).
//  alu_op/alu_a/alu_b are driven every cycle from the current inputs, valid or not.
//   alu_c is captured only on accept.
//  Op 000 is a NOP: result forced to 0, not taken from alu_c; entry still flows.
//  rd=0: entry flows with its computed result. Writeback ignores it and it is
//   never a forwarding source.
//  Arithmetic width is XLEN. Overflow wraps. slt is unsigned. slts is signed 2's
//   complement.
//  Flush (synchronous, edge N): buffer emptied after N, out_valid=0, no accept in
//   cycle N (in_ready=0), so no push. A pop coinciding with flush is still a commit.
//  rst_n low mid-operation empties the buffer immediately (async). Buffered results
//   are lost.
//  State: count in {0,1,2}; read/write pointers wrap modulo 2.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_result=0. Release ->
//    in_ready=1 next cycle.
//  2 Basic: add a=5,b=7,rd=3 with out_ready=1 -> next cycle out_valid=1, out_rd=3,
//    out_result=12. Repeat for sub 5-7 -> 0xFFFFFFFE. Repeat for slts
//    0xFFFFFFFF,1 -> 1 and slt 0xFFFFFFFF,1 -> 0.
//  3 Forwarding: out_ready=0. Push add r4=1+1, then xor r4=3^3. Then push or
//    rs1=4, a=0x99, imm=0, use_imm=1 -> result 0 (youngest r4=0, not 2 or 0x99).
//  4 Backpressure/full: out_ready=0, push 2 ops -> in_ready=0. Assert out_ready
//    with a third op valid -> push+pop same cycle, count stays 2, order preserved.
//  5 Flush: buffer holding 2 entries, flush=1 with in_valid=1 -> next cycle
//    out_valid=0, input not accepted, later ops see no stale forwarding.
//  6 Edge cases: op 000 -> result 0. rd=0 entry then rs1=0 reader -> reads in_a,
//    no forward. Async reset mid-stream clears out_valid without a clock edge.

Source files
------------

// File: rtl/l2k_exec_stage.sv
// Limn2600 execute stage: operand select/forwarding into an external ALU and a
// 2-entry result FIFO feeding writeback.
module l2k_exec_stage #(
  parameter int XLEN  = 32,
  parameter int RIDXW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [RIDXW-1:0] in_rs1,
  input  logic [RIDXW-1:0] in_rs2,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic             in_use_imm,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [RIDXW-1:0] in_rd,
  output logic [2:0]       alu_op,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RIDXW-1:0] out_rd,
  output logic [XLEN-1:0]  out_result
);

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [RIDXW-1:0] rd_q  [2];
  logic [XLEN-1:0]  res_q [2];
  logic             accept;
  logic             pop;
  logic             young;
  logic [XLEN-1:0]  result;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = !flush & ((count < 2'd2) | out_ready);
  assign accept    = in_valid & in_ready;
  assign young     = ~wr_ptr;

  assign out_rd     = out_valid ? rd_q[rd_ptr]  : '0;
  assign out_result = out_valid ? res_q[rd_ptr] : '0;

  // Youngest match wins; with one entry the young slot is also the head.
  // A popping head is still a valid source since its regfile write lands this edge.
  function automatic logic [XLEN-1:0] fwd(input logic [RIDXW-1:0] rs,
                                          input logic [XLEN-1:0]  rf);
    logic [XLEN-1:0] v;
    v = rf;
    if (rs != '0) begin
      if (count != 2'd0 && rd_q[young] == rs)
        v = res_q[young];
      else if (count == 2'd2 && rd_q[rd_ptr] == rs)
        v = res_q[rd_ptr];
    end
    return v;
  endfunction

  always_comb begin
    alu_op = in_op;
    alu_a  = fwd(in_rs1, in_a);
    alu_b  = in_use_imm ? in_imm : fwd(in_rs2, in_b);
  end

  assign result = (in_op == 3'b000) ? '0 : alu_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rd_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) begin
        rd_q[wr_ptr]  <= in_rd;
        res_q[wr_ptr] <= result;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_l2k_exec_stage.sv
// Directed bench for l2k_exec_stage; a small ALU model closes the alu_* loop.
module tb_l2k_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_a, in_b, in_imm;
  logic        in_use_imm;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  l2k_exec_stage #(.XLEN(32), .RIDXW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_a(in_a), .in_b(in_b),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rd(in_rd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result)
  );

  // NOP returns garbage so the stage's zero-forcing is observable.
  always_comb begin
    case (alu_op)
      3'b111:  alu_c = alu_a + alu_b;
      3'b110:  alu_c = alu_a - alu_b;
      3'b011:  alu_c = alu_a & alu_b;
      3'b010:  alu_c = alu_a ^ alu_b;
      3'b001:  alu_c = alu_a | alu_b;
      3'b101:  alu_c = {31'b0, (alu_a < alu_b)};
      3'b100:  alu_c = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_c = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] a, input logic [31:0] b, input logic ui,
                     input logic [31:0] imm, input logic [4:0] rd);
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_a = a; in_b = b;
    in_use_imm = ui; in_imm = imm; in_rd = rd; in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] a, input logic [31:0] b, input logic ui,
                      input logic [31:0] imm, input logic [4:0] rd);
    @(negedge clk);
    put(op, rs1, rs2, a, b, ui, imm, rd);
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    put(3'b111, 5'd0, 5'd0, 32'd9, 32'd9, 1'b0, 32'd0, 5'd1);

    // reset held with a valid op on the input
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_still_empty", out_valid, 0);

    // basic ops, writeback always ready
    @(negedge clk); out_ready = 1'b1;
    push(3'b111, 5'd0, 5'd0, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3);
    check("add_valid", out_valid, 1);
    check("add_rd", out_rd, 3);
    check("add_result", out_result, 12);
    push(3'b110, 5'd0, 5'd0, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3);
    check("sub_result", out_result, 32'hFFFF_FFFE);
    push(3'b100, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd5);
    check("slts_result", out_result, 1);
    check("slts_rd", out_rd, 5);
    push(3'b101, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd6);
    check("slt_result", out_result, 0);
    @(posedge clk); #1;
    check("basic_drained", out_valid, 0);

    // youngest-match forwarding
    @(negedge clk); out_ready = 1'b0;
    push(3'b111, 5'd0, 5'd0, 32'd1, 32'd1, 1'b0, 32'd0, 5'd4);
    push(3'b010, 5'd0, 5'd0, 32'd3, 32'd3, 1'b0, 32'd0, 5'd4);
    check("fwd_full_in_ready", in_ready, 0);
    @(negedge clk);
    put(3'b001, 5'd4, 5'd0, 32'h99, 32'd0, 1'b1, 32'd0, 5'd5);
    #1;
    check("fwd_alu_a_youngest", alu_a, 0);
    check("fwd_alu_b_imm", alu_b, 0);
    out_ready = 1'b1;
    #1;
    check("fwd_in_ready_pop", in_ready, 1);
    step();
    check("fwd_head_xor_rd", out_rd, 4);
    check("fwd_head_xor_res", out_result, 0);
    @(posedge clk); #1;
    check("fwd_or_rd", out_rd, 5);
    check("fwd_or_res", out_result, 0);
    @(posedge clk); #1;
    check("fwd_drained", out_valid, 0);

    // popping head still forwards, on both A and B
    @(negedge clk); out_ready = 1'b0;
    push(3'b111, 5'd0, 5'd0, 32'd10, 32'd20, 1'b0, 32'd0, 5'd6);
    @(negedge clk);
    out_ready = 1'b1;
    put(3'b111, 5'd6, 5'd6, 32'd0, 32'd0, 1'b0, 32'd0, 5'd7);
    #1;
    check("popfwd_alu_b", alu_b, 30);
    step();
    check("popfwd_rd", out_rd, 7);
    check("popfwd_res", out_result, 60);
    @(posedge clk); #1;

    // backpressure and full push+pop
    @(negedge clk); out_ready = 1'b0;
    push(3'b111, 5'd0, 5'd0, 32'd1, 32'd2, 1'b0, 32'd0, 5'd1);
    push(3'b111, 5'd0, 5'd0, 32'd4, 32'd4, 1'b0, 32'd0, 5'd2);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_head_rd", out_rd, 1);
    @(negedge clk);
    check("bp_head_stable", out_result, 3);
    out_ready = 1'b1;
    put(3'b110, 5'd0, 5'd0, 32'd10, 32'd3, 1'b0, 32'd0, 5'd3);
    #1;
    check("bp_in_ready_pop", in_ready, 1);
    step();
    check("bp_head2_rd", out_rd, 2);
    check("bp_head2_res", out_result, 8);
    out_ready = 1'b0;
    #1;
    check("bp_still_full", in_ready, 0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_head3_rd", out_rd, 3);
    check("bp_head3_res", out_result, 7);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // flush with an op offered
    @(negedge clk); out_ready = 1'b0;
    push(3'b011, 5'd0, 5'd0, 32'hF0, 32'hFF, 1'b0, 32'd0, 5'd8);
    push(3'b001, 5'd0, 5'd0, 32'd1, 32'd2, 1'b0, 32'd0, 5'd9);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    put(3'b111, 5'd8, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd10);
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    @(negedge clk);
    put(3'b111, 5'd8, 5'd9, 32'd100, 32'd200, 1'b0, 32'd0, 5'd11);
    #1;
    check("flush_no_stale_a", alu_a, 100);
    step();
    check("flush_next_rd", out_rd, 11);
    check("flush_next_res", out_result, 300);
    @(posedge clk); #1;

    // nop and rd=0
    push(3'b000, 5'd0, 5'd0, 32'd5, 32'd5, 1'b0, 32'd0, 5'd12);
    check("nop_valid", out_valid, 1);
    check("nop_rd", out_rd, 12);
    check("nop_result", out_result, 0);
    push(3'b111, 5'd0, 5'd0, 32'd50, 32'd0, 1'b0, 32'd0, 5'd0);
    check("rd0_rd", out_rd, 0);
    check("rd0_result", out_result, 50);
    @(negedge clk);
    put(3'b111, 5'd0, 5'd0, 32'd7, 32'd0, 1'b1, 32'd1, 5'd13);
    #1;
    check("rd0_no_fwd_a", alu_a, 7);
    step();
    check("rd0_reader_res", out_result, 8);
    @(posedge clk); #1;

    // async reset mid-stream
    @(negedge clk); out_ready = 1'b0;
    push(3'b111, 5'd0, 5'd0, 32'd1, 32'd1, 1'b0, 32'd0, 5'd14);
    push(3'b111, 5'd0, 5'd0, 32'd2, 32'd2, 1'b0, 32'd0, 5'd15);
    check("areset_pre_valid", out_valid, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_out_result", out_result, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("areset_in_ready", in_ready, 1);
    check("areset_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
